rng_arbiter: RTL and testbench
==============================

RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter OUT_WIDTH, default 9: random word width, equal to the RNG output width.
REQ-003 SHALL have parameter STIR_CYCLES, default 4: RNG advance pulses per draw (1..15).
REQ-004 SHALL have parameter FREE_RUN, default 1: 1 = RNG advances every cycle while IDLE.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  in  NUM_REQ  per-requester draw request, level, held until granted.
REQ-008 SHALL have port reseed  in  1  one-cycle pulse, restart RNG sequence.
REQ-009 SHALL have port rng_out  in  OUT_WIDTH  current RNG output word.
REQ-010 SHALL have port rng_ce  out  1  RNG clock enable.
REQ-011 SHALL have port rng_rst  out  1  RNG synchronous reset, active-high.
REQ-012 SHALL have port gnt  out  NUM_REQ  one-hot grant, one-cycle pulse.
REQ-013 SHALL have port data  out  OUT_WIDTH  random word delivered with gnt.
REQ-014 SHALL have port valid  out  1  data valid, one-cycle pulse coincident with gnt.

Function
REQ-015 SHALL implement FSM states IDLE, STIR, GRANT; all outputs registered except rng_ce and rng_rst, which are decoded from state.
REQ-016 In IDLE, rng_ce SHALL equal FREE_RUN.
REQ-017 In IDLE with any req bit set, the block SHALL latch winner = first set index strictly after last_gnt, in ascending modulo-NUM_REQ order, and go to STIR next cycle.
REQ-018 In STIR, rng_ce SHALL be 1 for exactly STIR_CYCLES consecutive cycles, counted by a 4-bit counter; the last cycle SHALL transition to GRANT.
REQ-019 In GRANT, rng_ce SHALL be 0 and data SHALL capture rng_out.
REQ-020 If req[winner] is still 1 in GRANT, the block SHALL assert gnt[winner] and valid on the next cycle for one cycle, set last_gnt = winner, and return to IDLE.
REQ-021 If req[winner] has dropped by GRANT, the block SHALL assert no gnt/valid, leave last_gnt unchanged, and return to IDLE (abort).
REQ-022 Request-to-grant latency SHALL be STIR_CYCLES+2 cycles from the IDLE cycle in which req is sampled.
REQ-023 Requests arriving while not IDLE SHALL wait; winner SHALL NOT change once latched.
REQ-024 gnt SHALL never have more than one bit set; valid SHALL equal |gnt every cycle.
REQ-025 reseed in any state SHALL drive rng_rst=1 in that same cycle (combinational), force rng_ce=0, abort any draw in progress (no gnt/valid), and return to IDLE; last_gnt SHALL be unchanged.
REQ-026 Back-to-back draws SHALL be separated by at least one IDLE cycle.
REQ-027 With STIR_CYCLES outside 1..15, behaviour is undefined; a simulation assertion SHALL flag it.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, counter=0, gnt=0, valid=0, data=0, last_gnt=NUM_REQ-1 (so requester 0 wins first).
REQ-029 During rst_n low, rng_ce SHALL be 0 and rng_rst SHALL be 1.
REQ-030 Deassertion of rst_n SHALL take effect on the next rising clk edge; the first grant is possible STIR_CYCLES+2 cycles after req is sampled.

Verification
REQ-031 Single request: req=4'b0001 held, STIR_CYCLES=4 -> rng_ce high 4 cycles, gnt=4'b0001 and valid exactly 6 cycles after sample, data equals rng_out sampled in GRANT.
REQ-032 Round-robin: req=4'b1111 held -> grants in order 0,1,2,3,0; each separated by >=1 IDLE cycle.
REQ-033 Abort: req[2] alone, drop it during STIR -> no gnt/valid; next request from req[2] still wins (last_gnt unchanged).
REQ-034 Reseed mid-STIR -> rng_rst=1 that cycle, rng_ce=0, no grant, IDLE next cycle; the request is re-served afterwards with a fresh STIR.
REQ-035 Async reset mid-GRANT: rst_n low between edges -> valid/gnt=0 immediately; after release, req=4'b1010 -> requester 1 granted first.
REQ-036 FREE_RUN=0, no requests for 100 cycles -> rng_ce stays 0 throughout; gnt never multi-hot (assertion).

Source files
------------

// File: rtl/rng_arbiter.sv
// Round-robin arbiter handing out random words: each draw stirs an external RNG
// for STIR_CYCLES enables, then delivers the RNG word to the latched winner.
module rng_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int OUT_WIDTH   = 9,
  parameter int STIR_CYCLES = 4,
  parameter int FREE_RUN    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 reseed,
  input  logic [OUT_WIDTH-1:0] rng_out,
  output logic                 rng_ce,
  output logic                 rng_rst,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [OUT_WIDTH-1:0] data,
  output logic                 valid
);

  localparam int               IDX_W     = $clog2(NUM_REQ);
  localparam logic [3:0]       CNT_LAST  = 4'(STIR_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, STIR, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic                   valid_q, valid_d;
  logic [OUT_WIDTH-1:0]   data_q, data_d;

  // First set request strictly after 'last', scanning upward with wrap-around.
  function automatic logic [IDX_W-1:0] pick_next(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] idx;
    logic             found;
    w     = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      last_q  <= LAST_INIT;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    last_d  = last_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    data_d  = data_q;
    if (reseed) begin
      // A reseed kills any draw in flight; fairness history is kept.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            win_d   = pick_next(req, last_q);
            cnt_d   = '0;
            state_d = STIR;
          end
        end
        STIR: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = GRANT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        GRANT: begin
          data_d  = rng_out;
          state_d = IDLE;
          if (req[win_q]) begin
            gnt_d[win_q] = 1'b1;
            valid_d      = 1'b1;
            last_d       = win_q;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // RNG controls are decoded from state so a reseed or reset acts in the same cycle.
  always_comb begin
    rng_rst = !rst_n || reseed;
    rng_ce  = 1'b0;
    if (rst_n && !reseed) begin
      case (state_q)
        IDLE:    rng_ce = (FREE_RUN != 0);
        STIR:    rng_ce = 1'b1;
        default: rng_ce = 1'b0;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign data  = data_q;

  always @(posedge clk) begin
    if (rst_n) begin
      assert (STIR_CYCLES >= 1 && STIR_CYCLES <= 15);
      assert ($onehot0(gnt_q));
      assert (valid_q == (|gnt_q));
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: draw-level reference model checked every cycle plus directed scenarios.
module tb_rng_arbiter;

  localparam int N = 4;
  localparam int W = 9;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic         reseed = 1'b0;
  logic [W-1:0] rng_out = '0;
  logic         rng_ce, rng_rst, valid;
  logic [N-1:0] gnt;
  logic [W-1:0] data;

  logic [N-1:0] req2 = '0;
  logic         reseed2 = 1'b0;
  logic         rng_ce2, rng_rst2, valid2;
  logic [N-1:0] gnt2;
  logic [W-1:0] data2;

  int errors = 0;
  int checks = 0;

  rng_arbiter #(.NUM_REQ(N), .OUT_WIDTH(W), .STIR_CYCLES(S), .FREE_RUN(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .reseed(reseed), .rng_out(rng_out),
    .rng_ce(rng_ce), .rng_rst(rng_rst), .gnt(gnt), .data(data), .valid(valid));

  rng_arbiter #(.NUM_REQ(N), .OUT_WIDTH(W), .STIR_CYCLES(S), .FREE_RUN(0)) dut_nofree (
    .clk(clk), .rst_n(rst_n), .req(req2), .reseed(reseed2), .rng_out(rng_out),
    .rng_ce(rng_ce2), .rng_rst(rng_rst2), .gnt(gnt2), .data(data2), .valid(valid2));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a draw is described by its age in cycles since the request was sampled.
  bit           m_busy  = 0;
  int           m_age   = 0;
  int           m_win   = 0;
  int           m_last  = N - 1;
  logic [N-1:0] m_gnt   = '0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic exp_ce;
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_last = N - 1;
      m_gnt = '0; m_valid = 1'b0; m_data = '0;
    end
    if (!rst_n || reseed) exp_ce = 1'b0;
    else if (!m_busy)     exp_ce = 1'b1;
    else                  exp_ce = (m_age <= S);
    check("rng_ce", 32'(rng_ce), 32'(exp_ce));
    check("rng_rst", 32'(rng_rst), 32'(!rst_n || reseed));
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("valid", 32'(valid), 32'(m_valid));
    check("data", 32'(data), 32'(m_data));
    check("nofree_ce", 32'(rng_ce2), 32'(0));
    check("nofree_gnt", 32'({valid2, gnt2, rng_rst2 && rst_n, data2}), 32'(0));
    if (rst_n) begin
      m_gnt   = '0;
      m_valid = 1'b0;
      if (reseed) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (|req) begin
          m_win  = rr_pick(req, m_last);
          m_busy = 1;
          m_age  = 1;
        end
      end else if (m_age <= S) begin
        m_age++;
      end else begin
        m_data = rng_out;
        if (req[m_win]) begin
          m_gnt[m_win] = 1'b1;
          m_valid      = 1'b1;
          m_last       = m_win;
        end
        m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Waits for a grant pulse; returns at 2 time units after the edge that showed it.
  task automatic wait_grant(input int bound, output int idx, output int n,
                            output logic [7:0] ce_bits);
    idx = -1; n = 0; ce_bits = '0;
    while (idx < 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
      if (n < 8) ce_bits[3'(n)] = rng_ce;
      for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
    end
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int idx, n;
    logic [7:0] ceb;
    int order[5];

    #1 rst_n = 1'b0;
    #1 check("reset_gnt", 32'({valid, gnt}), 32'(0));
    check("reset_ctl", 32'({rng_ce, rng_rst}), 32'b01);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single requester, known RNG word.
    rng_out = 9'h1A5;
    req = 4'b0001;
    wait_grant(20, idx, n, ceb);
    check("t1_idx", 32'(idx), 32'(0));
    check("t1_latency", 32'(n), 32'(6));
    check("t1_ce_pattern", 32'(ceb[5:1]), 32'b01111);
    check("t1_data", 32'(data), 32'h1A5);
    req = 4'b0000;
    tick(); tick();

    // Round robin from a fresh reset.
    pulse_reset();
    rng_out = 9'h0C3;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(20, idx, n, ceb);
      order[g] = idx;
      check("t2_spacing", 32'(n), 32'(6));
    end
    req = 4'b0000;
    check("t2_order0", 32'(order[0]), 32'(0));
    check("t2_order1", 32'(order[1]), 32'(1));
    check("t2_order2", 32'(order[2]), 32'(2));
    check("t2_order3", 32'(order[3]), 32'(3));
    check("t2_order4", 32'(order[4]), 32'(0));
    tick(); tick();

    // Abort: requester 2 withdraws during stir; history must not advance.
    req = 4'b0100;
    tick(); tick(); tick();
    req = 4'b0000;
    wait_grant(12, idx, n, ceb);
    check("t3_no_grant", 32'(idx), 32'hFFFF_FFFF);
    req = 4'b1100;
    wait_grant(20, idx, n, ceb);
    check("t3_winner", 32'(idx), 32'(2));
    req = 4'b0000;
    tick(); tick();

    // Reseed in the middle of a stir.
    req = 4'b0001;
    tick(); tick();
    reseed = 1'b1;
    #1 check("t4_rng_rst", 32'(rng_rst), 32'(1));
    check("t4_rng_ce", 32'(rng_ce), 32'(0));
    tick();
    reseed = 1'b0;
    wait_grant(20, idx, n, ceb);
    check("t4_idx", 32'(idx), 32'(0));
    check("t4_latency", 32'(n), 32'(6));
    req = 4'b0000;
    tick(); tick();

    // Asynchronous reset while the grant pulse is showing.
    req = 4'b0100;
    wait_grant(20, idx, n, ceb);
    check("t5_pre_idx", 32'(idx), 32'(2));
    rst_n = 1'b0;
    #1 check("t5_async_clear", 32'({valid, gnt}), 32'(0));
    check("t5_rst_ctl", 32'({rng_ce, rng_rst}), 32'b01);
    req = 4'b0000;
    tick(); tick();
    rst_n = 1'b1;
    req = 4'b1010;
    wait_grant(20, idx, n, ceb);
    check("t5_first_idx", 32'(idx), 32'(1));
    check("t5_latency", 32'(n), 32'(6));
    req = 4'b0000;
    tick();

    // Randomised traffic: requesters hold until granted, occasionally give up; rare reseeds.
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] r;
      r = req & ~gnt;
      for (int i = 0; i < N; i++) begin
        if (!r[i] && $urandom_range(3) == 0) r[i] = 1'b1;
        else if (r[i] && $urandom_range(15) == 0) r[i] = 1'b0;
      end
      req     = r;
      reseed  = ($urandom_range(39) == 0);
      rng_out = W'($urandom);
      tick();
    end
    reseed = 1'b0;
    req = '0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
